// File: rtl/bg_scan_sequencer_pkg.sv
// rtl/bg_scan_sequencer_pkg.sv - bg_scan_pkg: BG mode type, MMIO field positions, mode/slot lookup
package bg_scan_pkg;

  typedef enum logic [2:0] {
    MODE0 = 3'd0,
    MODE1 = 3'd1,
    MODE2 = 3'd2,
    MODE3 = 3'd3,
    MODE4 = 3'd4,
    MODE5 = 3'd5
  } bgmode_t;

  localparam int DISPCNT_MODE_LSB = 0;
  localparam int DISPCNT_MODE_MSB = 2;
  localparam int DISPCNT_BGEN_LSB = 8;
  localparam int DISPCNT_BGEN_MSB = 11;
  localparam int MOSAIC_HSIZE_LSB = 0;
  localparam int MOSAIC_HSIZE_MSB = 3;
  localparam int MOSAIC_VSIZE_LSB = 4;
  localparam int MOSAIC_VSIZE_MSB = 7;

  // Which of the four hardware BG slots the given video mode can display
  function automatic logic mode_ok(input logic [2:0] mode, input logic [1:0] slot);
    logic ok;
    ok = 1'b0;
    case (mode)
      MODE0:               ok = 1'b1;
      MODE1:               ok = (slot != 2'd3);
      MODE2:               ok = slot[1];
      MODE3, MODE4, MODE5: ok = (slot == 2'd2);
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/bg_tag_pipeline.sv
// rtl/bg_tag_pipeline.sv - WIDTH x DEPTH free-running tag shift register with async reset
module bg_tag_pipeline #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             rst_b,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/bg_scan_sequencer.sv
// rtl/bg_scan_sequencer.sv - BG scan/timing sequencer; mosaic tracking built only with BG_SCAN_MOSAIC_EN
module bg_scan_sequencer
  import bg_scan_pkg::*;
#(
  parameter int NUM_BG     = 4,
  parameter int H_TOTAL    = 308,
  parameter int V_TOTAL    = 228,
  parameter int H_VISIBLE  = 240,
  parameter int V_VISIBLE  = 160,
  parameter int PIPE_DEPTH = 2,
  localparam int CW = $clog2(H_TOTAL),
  localparam int BW = $clog2(NUM_BG),
  localparam int RW = $clog2(V_TOTAL)
) (
  input  logic          clock,
  input  logic          rst_b,
  input  logic          enable,
  input  logic [15:0]   dispcnt,
  input  logic [15:0]   mosaic,
  output logic [CW-1:0] col,
  output logic [BW-1:0] bgno,
  output logic [RW-1:0] row,
  output logic          frame,
  output logic          start_row,
  output logic          new_frame,
  output logic          hblank,
  output logic          vblank,
  output logic          bgused,
  output logic [CW-1:0] mosaic_col,
  output logic [RW-1:0] mosaic_row,
  output logic [CW-1:0] col_out,
  output logic [BW-1:0] bgno_out,
  output logic          bgused_out,
  output logic          valid_out
);

  logic bgno_last, col_last, row_last;
  logic unused_bits;

  assign bgno_last = (bgno == BW'(NUM_BG - 1));
  assign col_last  = (col == CW'(H_TOTAL - 1));
  assign row_last  = (row == RW'(V_TOTAL - 1));
  assign start_row = enable & col_last & bgno_last;
  assign new_frame = start_row & row_last;
  assign hblank    = (col >= CW'(H_VISIBLE));
  assign vblank    = (row >= RW'(V_VISIBLE));

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      bgno  <= '0;
      col   <= '0;
      row   <= '0;
      frame <= 1'b0;
    end else if (enable) begin
      if (bgno_last) begin
        bgno <= '0;
        if (col_last) begin
          col <= '0;
          if (row_last) begin
            row   <= '0;
            frame <= ~frame;
          end else begin
            row <= row + RW'(1);
          end
        end else begin
          col <= col + CW'(1);
        end
      end else begin
        bgno <= bgno + BW'(1);
      end
    end
  end

  // Per-line DISPCNT shadow; first clock after reset loads it unconditionally
  logic       loaded;
  logic [2:0] shadow_mode;
  logic [3:0] shadow_en;

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      loaded      <= 1'b0;
      shadow_mode <= '0;
      shadow_en   <= '0;
    end else if (!loaded || start_row) begin
      loaded      <= 1'b1;
      shadow_mode <= dispcnt[DISPCNT_MODE_MSB:DISPCNT_MODE_LSB];
      shadow_en   <= dispcnt[DISPCNT_BGEN_MSB:DISPCNT_BGEN_LSB];
    end
  end

  logic [3:0] en_eff;
  logic [1:0] slot;
  logic       in_range;

  assign en_eff = loaded ? shadow_en : dispcnt[DISPCNT_BGEN_MSB:DISPCNT_BGEN_LSB];
  assign slot   = 2'(bgno);

  if (BW > 2) begin : g_wide_slot
    assign in_range = ~|bgno[BW-1:2];
  end else begin : g_narrow_slot
    assign in_range = 1'b1;
  end

  assign bgused = in_range & en_eff[slot] & mode_ok(shadow_mode, slot);

  localparam int TW = CW + BW + 2;
  logic [TW-1:0] tag_in, tag_out;

  assign tag_in = {col, bgno, bgused, enable & ~hblank & ~vblank};

  bg_tag_pipeline #(
    .WIDTH (TW),
    .DEPTH (PIPE_DEPTH)
  ) u_tag_pipe (
    .clock (clock),
    .rst_b (rst_b),
    .din   (tag_in),
    .dout  (tag_out)
  );

  assign {col_out, bgno_out, bgused_out, valid_out} = tag_out;

`ifdef BG_SCAN_MOSAIC_EN
  logic [3:0] hsize, vsize, hcnt, vcnt;
  logic       col_done;

  assign col_done = enable & bgno_last;

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      hsize      <= '0;
      vsize      <= '0;
      hcnt       <= '0;
      vcnt       <= '0;
      mosaic_col <= '0;
      mosaic_row <= '0;
    end else begin
      if (new_frame) begin
        hsize <= mosaic[MOSAIC_HSIZE_MSB:MOSAIC_HSIZE_LSB];
        vsize <= mosaic[MOSAIC_VSIZE_MSB:MOSAIC_VSIZE_LSB];
      end
      // Line start restarts the horizontal block; frame start restarts the vertical one
      if (start_row) begin
        hcnt       <= '0;
        mosaic_col <= '0;
      end else if (col_done) begin
        if (hcnt == hsize) begin
          hcnt       <= '0;
          mosaic_col <= col + CW'(1);
        end else begin
          hcnt <= hcnt + 4'd1;
        end
      end
      if (new_frame) begin
        vcnt       <= '0;
        mosaic_row <= '0;
      end else if (start_row) begin
        if (vcnt == vsize) begin
          vcnt       <= '0;
          mosaic_row <= row + RW'(1);
        end else begin
          vcnt <= vcnt + 4'd1;
        end
      end
    end
  end

  assign unused_bits = ^{dispcnt[15:12], dispcnt[7:3], mosaic[15:8]};
`else
  assign mosaic_col  = col;
  assign mosaic_row  = row;
  assign unused_bits = ^{dispcnt[15:12], dispcnt[7:3], mosaic};
`endif

endmodule

// File: tb/tb_bg_scan_sequencer.sv
// tb/tb_bg_scan_sequencer.sv - self-checking bench for bg_scan_sequencer (reduced V raster)
module tb_bg_scan_sequencer;

  localparam int NB = 4, HT = 308, VT = 12, HV = 240, VV = 8, PD = 2;
  localparam int CW = 9, BW = 2, RW = 4;
  localparam int LINE = NB * HT;
  localparam int FRAME = LINE * VT;

  logic          clock = 1'b0;
  logic          rst_b = 1'b0;
  logic          enable = 1'b0;
  logic [15:0]   dispcnt = 16'h0000;
  logic [15:0]   mosaic = 16'h0000;
  logic [CW-1:0] col, mosaic_col, col_out;
  logic [BW-1:0] bgno, bgno_out;
  logic [RW-1:0] row, mosaic_row;
  logic          frame, start_row, new_frame, hblank, vblank, bgused, bgused_out, valid_out;

  always #5 clock = ~clock;

  bg_scan_sequencer #(
    .NUM_BG(NB), .H_TOTAL(HT), .V_TOTAL(VT), .H_VISIBLE(HV), .V_VISIBLE(VV), .PIPE_DEPTH(PD)
  ) dut (
    .clock(clock), .rst_b(rst_b), .enable(enable), .dispcnt(dispcnt), .mosaic(mosaic),
    .col(col), .bgno(bgno), .row(row), .frame(frame), .start_row(start_row),
    .new_frame(new_frame), .hblank(hblank), .vblank(vblank), .bgused(bgused),
    .mosaic_col(mosaic_col), .mosaic_row(mosaic_row), .col_out(col_out),
    .bgno_out(bgno_out), .bgused_out(bgused_out), .valid_out(valid_out)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: position counts enabled clocks since reset release
  int         pos = 0;
  bit         loaded = 1'b0;
  logic [2:0] sh_mode = '0;
  logic [3:0] sh_en = '0;
  logic [3:0] hs = '0, vs = '0;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [BW-1:0] b;
    logic          u;
    logic          v;
  } tag_t;
  tag_t sb_q[$];
  tag_t t_push, t_pop;

  function automatic int e_bgno(); return pos % NB; endfunction
  function automatic int e_col();  return (pos / NB) % HT; endfunction
  function automatic int e_row();  return (pos / LINE) % VT; endfunction
  function automatic int e_frame(); return (pos / FRAME) % 2; endfunction

  function automatic logic [3:0] mode_mask(input logic [2:0] m);
    case (m)
      3'd0: return 4'b1111;
      3'd1: return 4'b0111;
      3'd2: return 4'b1100;
      3'd3, 3'd4, 3'd5: return 4'b0100;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic e_used();
    logic [3:0] en, avail;
    en = loaded ? sh_en : dispcnt[11:8];
    avail = en & mode_mask(loaded ? sh_mode : 3'd0);
    return avail[e_bgno()];
  endfunction

  function automatic logic e_start();
    return enable && (e_bgno() == NB - 1) && (e_col() == HT - 1);
  endfunction

  function automatic logic e_newf();
    return e_start() && (e_row() == VT - 1);
  endfunction

`ifdef BG_SCAN_MOSAIC_EN
  function automatic int e_mcol(); return (e_col() / (int'(hs) + 1)) * (int'(hs) + 1); endfunction
  function automatic int e_mrow(); return (e_row() / (int'(vs) + 1)) * (int'(vs) + 1); endfunction
`else
  function automatic int e_mcol(); return e_col(); endfunction
  function automatic int e_mrow(); return e_row(); endfunction
`endif

  always @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      pos = 0; loaded = 1'b0; sh_mode = '0; sh_en = '0; hs = '0; vs = '0;
      sb_q.delete();
    end else begin
      t_push.c = CW'(e_col());
      t_push.b = BW'(e_bgno());
      t_push.u = e_used();
      t_push.v = enable && (e_col() < HV) && (e_row() < VV);
      sb_q.push_back(t_push);
      if (e_newf()) begin
        hs = mosaic[3:0];
        vs = mosaic[7:4];
      end
      if (!loaded || e_start()) begin
        loaded = 1'b1;
        sh_mode = dispcnt[2:0];
        sh_en = dispcnt[11:8];
      end
      if (enable) pos++;
    end
  end

  int          mism = 0, sb_mism = 0;
  logic [33:0] a_vec, e_vec, fa, fe;

  always @(negedge clock) begin
    if (rst_b) begin
      a_vec = {col, bgno, row, frame, start_row, new_frame, hblank, vblank, bgused, mosaic_col, mosaic_row};
      e_vec = {CW'(e_col()), BW'(e_bgno()), RW'(e_row()), e_frame() == 1, e_start(), e_newf(),
               e_col() >= HV, e_row() >= VV, e_used(), CW'(e_mcol()), RW'(e_mrow())};
      if (a_vec !== e_vec) begin
        if (mism == 0) begin fa = a_vec; fe = e_vec; end
        mism++;
      end
      if (sb_q.size() == PD) begin
        t_pop = sb_q.pop_front();
        if ({col_out, bgno_out, bgused_out, valid_out} !== t_pop) sb_mism++;
      end
    end
  end

  task automatic phase_end(input string name);
    if (mism != 0) $display("  %s first state diff: dut=%h model=%h", name, fa, fe);
    check({name, "_state_diffs"}, mism, 0);
    check({name, "_pipe_diffs"}, sb_mism, 0);
    mism = 0;
    sb_mism = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic wait_at(input int r, input int c, input int b, input string name);
    int n = 0;
    while (!((r < 0 || e_row() == r) && e_col() == c && e_bgno() == b) && n < FRAME + LINE) begin
      step(1);
      n++;
    end
    check({"reach_", name}, (n < FRAME + LINE), 1);
  endtask

  task automatic get_pattern(output logic [3:0] p);
    for (int s = 0; s < 4; s++) begin
      @(negedge clock);
      p[s] = bgused;
      @(posedge clock); #1;
    end
  endtask

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  pat;
  } vec_t;
  vec_t vt[11];

  int         nf, vb;
  logic [3:0] p, prev;

  initial begin
    vt[0]  = '{16'h0C02, 4'b1100};
    vt[1]  = '{16'h0F01, 4'b0111};
    vt[2]  = '{16'h0F00, 4'b1111};
    vt[3]  = '{16'h0403, 4'b0100};
    vt[4]  = '{16'h0F05, 4'b0100};
    vt[5]  = '{16'h0B04, 4'b0000};
    vt[6]  = '{16'h0F06, 4'b0000};
    vt[7]  = '{16'h0F07, 4'b0000};
    vt[8]  = '{16'h0500, 4'b0101};
    vt[9]  = '{16'h0A01, 4'b0010};
    vt[10] = '{16'hF3F8, 4'b0011};

    rst_b = 1'b0; enable = 1'b1; dispcnt = 16'h0F00; mosaic = 16'h0033;
    repeat (3) @(posedge clock);
    #4;
    check("reset_outputs", {col, bgno, row, frame, start_row, new_frame, hblank, vblank,
                            col_out, bgno_out, bgused_out, valid_out, mosaic_col, mosaic_row}, 0);
    check("reset_bgused", bgused, 1);
    @(posedge clock); #1;
    rst_b = 1'b1;

    for (int k = 0; k <= 4; k++) begin
      check($sformatf("start_bgno_c%0d", k), bgno, k % 4);
      check($sformatf("start_col_c%0d", k), col, k / 4);
      if (k < 4) step(1);
    end
    step(1227);
    check("start_row_c1231", start_row, 1);
    check("row_c1231", row, 0);
    step(1);
    check("row_c1232", {row, col, bgno, start_row}, {4'd1, 9'd0, 2'd0, 1'b0});
    phase_end("startup");

    nf = 0; vb = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clock);
      nf += int'(new_frame);
      vb += int'(vblank);
      if (pos == FRAME - 1) check("frame_end_pulse", {new_frame, frame, vblank}, 3'b101);
      if (pos == FRAME) check("frame_wrap_state", {frame, row, col, new_frame}, {1'b1, 4'd0, 9'd0, 1'b0});
      @(posedge clock); #1;
    end
    check("new_frame_count", nf, 1);
    check("vblank_cycles", vb, (VT - VV) * LINE);
    phase_end("frame");

`ifdef BG_SCAN_MOSAIC_EN
    for (int c = 0; c < 8; c++) begin
      check($sformatf("mosaic_col_%0d", c), mosaic_col, (c / 4) * 4);
      step(4);
    end
    wait_at(3, 0, 0, "mosaic_r3");
    check("mosaic_row_3", mosaic_row, 0);
    wait_at(4, 0, 0, "mosaic_r4");
    check("mosaic_row_4", mosaic_row, 4);
    phase_end("mosaic");
`endif

    wait_at(-1, 5, 2, "hold_point");
    enable = 1'b0;
    step(1);
    check("hold_valid_out_1", valid_out, 1);
    check("hold_pos_1", {col, bgno}, {9'd5, 2'd2});
    step(1);
    check("hold_valid_out_2", valid_out, 0);
    step(8);
    check("hold_pos_10", {col, bgno, valid_out}, {9'd5, 2'd2, 1'b0});
    enable = 1'b1;
    step(1);
    check("resume_pos", {col, bgno}, {9'd5, 2'd3});
    step(1);
    check("resume_valid_out", valid_out, 1);
    phase_end("hold");

    prev = 4'b1111;
    for (int i = 0; i < 11; i++) begin
      wait_at(-1, 50, 0, $sformatf("vec%0d_mid", i));
      dispcnt = vt[i].d;
      get_pattern(p);
      check($sformatf("used_hold_%0d", i), p, prev);
      wait_at(-1, 0, 0, $sformatf("vec%0d_next", i));
      get_pattern(p);
      check($sformatf("used_line_%0d", i), p, vt[i].pat);
      prev = vt[i].pat;
    end
    phase_end("bgused");

    wait_at(5, 100, 1, "mid_reset");
    @(posedge clock); #3;
    rst_b = 1'b0;
    #1;
    check("midreset_outputs", {col, bgno, row, frame, start_row, new_frame, hblank, vblank,
                               col_out, bgno_out, bgused_out, valid_out, mosaic_col, mosaic_row}, 0);
    check("midreset_bgused", bgused, 1);
    repeat (2) @(posedge clock);
    #1;
    rst_b = 1'b1;
    step(LINE);
    check("after_reset_pos", {frame, row, col, bgno}, {1'b0, 4'd1, 9'd0, 2'd0});
    phase_end("midreset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bg_scan_sequencer.md
Name: bg_scan_sequencer

Overview:
Parametrised scan/timing sequencer for the background processing pipeline. It generates the per-cycle (col, bgno) slot, row, frame and row/frame strobes. It also derives a per-slot "layer used" flag from a per-line shadow of DISPCNT, and delays slot tags through a configurable pipeline so they align with downstream VRAM data. It replaces the fixed 4-layer, 308x228 counter logic inside bg_processing_circuit, generalised in layer count, raster size and pipeline depth, and adds mosaic coordinate tracking.

Parameters:
NUM_BG, 4, background slots per column; power of two, >=2
H_TOTAL, 308, columns per line, including hblank
V_TOTAL, 228, lines per frame, including vblank
H_VISIBLE, 240, visible columns
V_VISIBLE, 160, visible lines
PIPE_DEPTH, 2, register stages between slot issue and the *_out tags; >=1

Ports:
clock  in  1  system clock
rst_b  in  1  asynchronous active-low reset
enable  in  1  1 = advance scan; 0 = freeze counters
dispcnt  in  16  DISPCNT MMIO; [2:0] bgmode, [11:8] BG0-3 enable
mosaic  in  16  MOSAIC MMIO; [3:0] hsize-1, [7:4] vsize-1
col  out  CW=$clog2(H_TOTAL)  current column
bgno  out  BW=$clog2(NUM_BG)  current background slot
row  out  RW=$clog2(V_TOTAL)  current line
frame  out  1  frame parity, for bitmap page select
start_row  out  1  last slot of line, combinational
new_frame  out  1  last slot of frame, combinational
hblank  out  1  col >= H_VISIBLE
vblank  out  1  row >= V_VISIBLE
bgused  out  1  current slot's layer active
mosaic_col  out  CW  column snapped to horizontal mosaic block
mosaic_row  out  RW  row snapped to vertical mosaic block
col_out  out  CW  col delayed PIPE_DEPTH cycles
bgno_out  out  BW  bgno delayed PIPE_DEPTH cycles
bgused_out  out  1  bgused delayed PIPE_DEPTH cycles
valid_out  out  1  delayed (enable & ~hblank & ~vblank)

Behaviour:
- Reset (async, rst_b=0): all counters, frame, shadow registers, mosaic state and pipeline stages go to 0. All outputs read 0, except combinational flags, which follow the zeroed state (bgused per dispcnt, mode shadow 0).
- When enable=1, each clock does the following:
  - bgno increments.
  - When bgno==NUM_BG-1, bgno wraps to 0 and col increments.
  - When col==H_TOTAL-1 as well, col wraps to 0 and row increments.
  - When row==V_TOTAL-1 as well, row wraps to 0 and frame toggles.
- When enable=0, all counters hold. Pipeline stages keep shifting, with valid forced to 0 at stage input.
- start_row = enable & (col==H_TOTAL-1) & (bgno==NUM_BG-1). new_frame = start_row & (row==V_TOTAL-1). Each is a single-cycle pulse.
- frame toggles only on new_frame and holds otherwise; start_row does not clear it.
- Shadow DISPCNT [2:0] and [11:8] is captured on start_row and on reset release. Mid-line writes take effect on the next line.
- bgused = shadow_en[bgno] & mode_ok(bgno). Indices >=4 always read 0. mode_ok by mode:
  - mode 0: slots 0-3
  - mode 1: slots 0, 1, 2
  - mode 2: slots 2, 3
  - modes 3-5: slot 2 only
  - modes 6-7: none
- Pipeline: PIPE_DEPTH stages of {col, bgno, bgused, valid}. Stages shift every clock and carry no enable. Latency is exactly PIPE_DEPTH cycles.
- Arithmetic: all counters are unsigned, with wrap by explicit compare, never natural overflow.
- Mosaic:
  - hsize/vsize are latched from mosaic on new_frame.
  - Horizontal: hcnt counts completed columns and is cleared on start_row. When hcnt==hsize, it clears and mosaic_col loads col+1; otherwise mosaic_col holds. mosaic_col is cleared on start_row.
  - Vertical: vcnt works the same per line, advancing on start_row and cleared on new_frame. mosaic_row loads row+1 on block boundary and is cleared on new_frame.
  - With size 0, mosaic_* equals col/row.
- Simultaneous events: new_frame implies start_row. Both wraps and the frame toggle occur in the same edge.

Optional Feature:
BG_SCAN_MOSAIC_EN.
- Defined: mosaic counters and latches are implemented as described above.
- Undefined: the mosaic input is ignored, mosaic_col=col and mosaic_row=row combinationally, and no mosaic registers are built.

Decomposition:
- Package bg_scan_pkg holds:
  - bgmode_t (3-bit mode enum, MODE0..MODE5)
  - the DISPCNT/MOSAIC field bit-position constants
  - the mode_ok lookup function
- One sub-module: bg_tag_pipeline, a parametrised width x PIPE_DEPTH shift register with async reset. It replaces chains of bg_pipeline instances.

Test Plan:
- Reset release with enable=1, defaults, dispcnt=0x0F00 (mode0, all BG) -> bgno cycles 0,1,2,3. col=1 at cycle 4. start_row at cycle 1231; row=1 at cycle 1232.
- Run 308*228*4=280896 cycles -> exactly one new_frame; frame 0->1; row=0, col=0; vblank high for rows 160-227.
- dispcnt mode2 (0x0C02) written mid-line -> bgused unchanged until start_row. Next line bgused=0,0,1,1 per column; bgused_out shows the same pattern 2 cycles later.
- enable low for 10 cycles at col=5, bgno=2 -> counters hold; valid_out falls 2 cycles later; resume continues from col=5, bgno=3.
- BG_SCAN_MOSAIC_EN, mosaic=0x0033 latched at frame start -> mosaic_col sequence 0,0,0,0,4,4,...; mosaic_row on rows 0-3=0, rows 4-7=4.
- rst_b asserted mid-frame at row=100 -> all outputs 0 immediately, asynchronous to clock; resumes from row 0, frame 0.
